// File: rtl/axi_xbar_if.sv
// AXI4-Lite channel bundle shared by the crossbar's upstream and downstream sides.
// master drives valids and request payload; slave drives readies and responses.
interface axi_xbar_if;
   logic        arvalid;
   logic        arready;
   logic [31:0] araddr;
   logic        rvalid;
   logic        rready;
   logic [31:0] rdata;
   logic        rresp;
   logic        awvalid;
   logic        awready;
   logic [31:0] awaddr;
   logic        wvalid;
   logic        wready;
   logic [31:0] wdata;
   logic [7:0]  wmask;
   logic        bvalid;
   logic        bready;
   logic        bresp;

   modport master (
      output arvalid, araddr, rready,
      output awvalid, awaddr, wvalid, wdata, wmask, bready,
      input  arready, rvalid, rdata, rresp,
      input  awready, wready, bvalid, bresp
   );

   modport slave (
      input  arvalid, araddr, rready,
      input  awvalid, awaddr, wvalid, wdata, wmask, bready,
      output arready, rvalid, rdata, rresp,
      output awready, wready, bvalid, bresp
   );
endinterface

// File: rtl/axi_xbar.sv
// AXI4-Lite 1-to-2 crossbar: s0 = main SRAM, s1 = device region, misses
// answered locally with an error response. One outstanding op per path.
module axi_xbar #(
   parameter logic [31:0] S0_BASE = 32'h8000_0000,
   parameter logic [31:0] S0_SIZE = 32'h0800_0000,
   parameter logic [31:0] S1_BASE = 32'ha000_0000,
   parameter logic [31:0] S1_SIZE = 32'h0001_0000
) (
   input  logic       clk,
   input  logic       reset,
   axi_xbar_if.slave  m,
   axi_xbar_if.master s0,
   axi_xbar_if.master s1
);
   typedef enum logic [1:0] {SEL_S0, SEL_S1, SEL_ERR} sel_e;
   typedef enum logic {R_IDLE, R_BUSY} rstate_e;
   typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wstate_e;

   // Offset compare keeps the hit test correct even if base+size wraps.
   function automatic sel_e decode(input logic [31:0] a);
      if (a >= S0_BASE && (a - S0_BASE) < S0_SIZE) return SEL_S0;
      if (a >= S1_BASE && (a - S1_BASE) < S1_SIZE) return SEL_S1;
      return SEL_ERR;
   endfunction

   rstate_e r_rstate;
   wstate_e r_wstate;
   sel_e    r_rsel;
   sel_e    r_wsel;
   sel_e    w_rdec;
   sel_e    w_wdec;
   sel_e    w_wtgt;
   logic    w_tawr;
   logic    w_twr;
   logic    w_fwdw;

   assign w_rdec = decode(m.araddr);
   assign w_wdec = decode(m.awaddr);
   assign w_wtgt = (r_wstate == W_IDLE) ? w_wdec : r_wsel;

   assign s0.araddr = m.araddr;
   assign s1.araddr = m.araddr;
   assign s0.awaddr = m.awaddr;
   assign s1.awaddr = m.awaddr;
   assign s0.wdata  = m.wdata;
   assign s1.wdata  = m.wdata;
   assign s0.wmask  = m.wmask;
   assign s1.wmask  = m.wmask;

   always_comb begin
      s0.arvalid = 1'b0;
      s1.arvalid = 1'b0;
      s0.rready  = 1'b0;
      s1.rready  = 1'b0;
      m.arready  = 1'b0;
      m.rvalid   = 1'b0;
      m.rdata    = '0;
      m.rresp    = 1'b0;
      if (r_rstate == R_IDLE) begin
         unique case (w_rdec)
            SEL_S0: begin
               s0.arvalid = m.arvalid;
               m.arready  = m.arvalid && s0.arready;
            end
            SEL_S1: begin
               s1.arvalid = m.arvalid;
               m.arready  = m.arvalid && s1.arready;
            end
            default: m.arready = m.arvalid;
         endcase
      end else begin
         unique case (r_rsel)
            SEL_S0: begin
               m.rvalid  = s0.rvalid;
               m.rdata   = s0.rdata;
               m.rresp   = s0.rresp;
               s0.rready = m.rready;
            end
            SEL_S1: begin
               m.rvalid  = s1.rvalid;
               m.rdata   = s1.rdata;
               m.rresp   = s1.rresp;
               s1.rready = m.rready;
            end
            default: begin
               m.rvalid = 1'b1;
               m.rresp  = 1'b1;
            end
         endcase
      end
   end

   always_comb begin
      w_tawr = 1'b1;
      w_twr  = 1'b1;
      unique case (w_wtgt)
         SEL_S0: begin
            w_tawr = s0.awready;
            w_twr  = s0.wready;
         end
         SEL_S1: begin
            w_tawr = s1.awready;
            w_twr  = s1.wready;
         end
         default: ;
      endcase
   end

   // W only travels once its AW is present or already accepted.
   always_comb begin
      w_fwdw    = 1'b0;
      m.awready = 1'b0;
      m.wready  = 1'b0;
      m.bvalid  = 1'b0;
      m.bresp   = 1'b0;
      s0.bready = 1'b0;
      s1.bready = 1'b0;
      unique case (r_wstate)
         W_IDLE: begin
            w_fwdw    = m.wvalid && m.awvalid;
            m.awready = m.awvalid && w_tawr;
            m.wready  = m.awvalid && m.wvalid && w_twr;
         end
         W_DATA: begin
            w_fwdw   = m.wvalid;
            m.wready = m.wvalid && w_twr;
         end
         W_RESP: begin
            unique case (r_wsel)
               SEL_S0: begin
                  m.bvalid  = s0.bvalid;
                  m.bresp   = s0.bresp;
                  s0.bready = m.bready;
               end
               SEL_S1: begin
                  m.bvalid  = s1.bvalid;
                  m.bresp   = s1.bresp;
                  s1.bready = m.bready;
               end
               default: begin
                  m.bvalid = 1'b1;
                  m.bresp  = 1'b1;
               end
            endcase
         end
         default: ;
      endcase
   end

   assign s0.awvalid = (r_wstate == W_IDLE) && (w_wtgt == SEL_S0) && m.awvalid;
   assign s1.awvalid = (r_wstate == W_IDLE) && (w_wtgt == SEL_S1) && m.awvalid;
   assign s0.wvalid  = (w_wtgt == SEL_S0) && w_fwdw;
   assign s1.wvalid  = (w_wtgt == SEL_S1) && w_fwdw;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_rstate <= R_IDLE;
         r_rsel   <= SEL_S0;
         r_wstate <= W_IDLE;
         r_wsel   <= SEL_S0;
      end else begin
         unique case (r_rstate)
            R_IDLE:
               if (m.arvalid && m.arready) begin
                  r_rsel   <= w_rdec;
                  r_rstate <= R_BUSY;
               end
            default:
               if (m.rvalid && m.rready) r_rstate <= R_IDLE;
         endcase
         unique case (r_wstate)
            W_IDLE:
               if (m.awvalid && m.awready) begin
                  r_wsel   <= w_wdec;
                  r_wstate <= (m.wvalid && m.wready) ? W_RESP : W_DATA;
               end
            W_DATA:
               if (m.wvalid && m.wready) r_wstate <= W_RESP;
            W_RESP:
               if (m.bvalid && m.bready) r_wstate <= W_IDLE;
            default: r_wstate <= W_IDLE;
         endcase
      end
   end
endmodule

// File: doc/axi_xbar.md
Name: axi_xbar

Overview:
- AXI4-Lite 1-to-2 crossbar with internal decode-error responder.
- Sits directly downstream of the two-master arbiter and takes its single slave-side port as input (m_*).
- Routes each transaction by address to either s0 (main SRAM) or s1 (device region: UART/CLINT).
- Addresses that hit neither region get an error response generated inside the block.
- Read and write paths are independent. Each path has at most one outstanding transaction.

Parameters:
- S0_BASE, 32'h8000_0000, s0 region base address.
- S0_SIZE, 32'h0800_0000, s0 region size in bytes; hit when S0_BASE <= addr < S0_BASE+S0_SIZE.
- S1_BASE, 32'ha000_0000, s1 region base address.
- S1_SIZE, 32'h0001_0000, s1 region size in bytes; same hit rule as s0.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- m_arvalid/m_arready  in/out  1/1  upstream read address handshake
- m_araddr  in  32  upstream read address
- m_rvalid/m_rready  out/in  1/1  upstream read data handshake
- m_rdata  out  32  upstream read data
- m_rresp  out  1  upstream read response, 1 = error
- m_awvalid/m_awready  in/out  1/1  upstream write address handshake
- m_awaddr  in  32  upstream write address
- m_wvalid/m_wready  in/out  1/1  upstream write data handshake
- m_wdata  in  32  upstream write data
- m_wmask  in  8  upstream write byte mask
- m_bvalid/m_bready  out/in  1/1  upstream write response handshake
- m_bresp  out  1  upstream write response, 1 = error
- sN_* (N = 0, 1): one full slave-side copy of every channel above per target, directions mirrored.

Behaviour:
- Clock and reset: one clock, clk; reset is synchronous and active-high.
- Reset: both FSMs go to IDLE; target registers clear to S0.
- Reset output values: with m_*valid low, every m_*ready, m_rvalid, m_bvalid, sN_*valid and sN_*ready is 0.
- Reset mid-transaction: the transaction is abandoned with no response.
- Decode: combinational from address. s0 hit wins if the regions overlap. A miss in both regions selects ERR.
- Pass-through: sN_araddr, sN_awaddr, sN_wdata and sN_wmask are driven to both slaves unconditionally. Only valids and readies are gated.

Read FSM (states R_IDLE, R_BUSY; registered rsel in {S0, S1, ERR}):
- R_IDLE:
  - s<dec>_arvalid = m_arvalid.
  - m_arready = m_arvalid && (dec==ERR ? 1 : s<dec>_arready).
  - On AR handshake: rsel <= dec, go to R_BUSY.
- R_BUSY:
  - m_arready = 0 and all sN_arvalid = 0.
  - If rsel is S0 or S1: m_rvalid, m_rdata and m_rresp come from the selected slave; that slave's rready = m_rready; the other slave's rready = 0.
  - If rsel is ERR: m_rvalid = 1, m_rdata = 0, m_rresp = 1.
  - On m_rvalid && m_rready: go to R_IDLE.
- Next AR can be accepted the cycle after the R handshake. No combinational path from R to AR.

Write FSM (states W_IDLE, W_DATA, W_RESP; registered wsel):
- W_IDLE:
  - Decode on m_awaddr.
  - s<dec>_awvalid = m_awvalid.
  - s<dec>_wvalid = m_wvalid && m_awvalid. W is never forwarded before AW is present.
  - Readies: m_awready = m_awvalid && target awready; m_wready = m_awvalid && m_wvalid && target wready. For ERR, target ready is 1.
  - AW handshake with W handshake in the same cycle: wsel <= dec, go to W_RESP.
  - AW handshake alone: wsel <= dec, go to W_DATA.
  - W handshake without AW handshake is illegal. Slaves must not assert wready without awready in the same cycle when both valids are high.
- W_DATA:
  - m_awready = 0; W is routed to wsel.
  - On W handshake: go to W_RESP.
- W_RESP:
  - B channel is routed from wsel. For ERR: m_bvalid = 1, m_bresp = 1.
  - On m_bvalid && m_bready: go to W_IDLE.
- Read and write may target different or the same slave concurrently; there is no cross-path ordering.
- Outputs to the non-selected slave stay 0 in every state.
- Latency: the crossbar adds zero cycles to every channel. Handshakes are combinational pass-through gated by FSM state.

Test Plan:
- Read 0x8000_0010; s0 arready=1, rvalid one cycle later with rdata=0xDEADBEEF -> m_rdata=0xDEADBEEF, m_rresp=0, s1_arvalid stays 0, FSM back to R_IDLE the next cycle.
- Read 0x0000_0000 -> m_arready=1 the same cycle; m_rvalid=1, m_rresp=1, m_rdata=0 the next cycle; no sN_arvalid ever asserted.
- Write 0xa000_03f8 with AW and W together, wmask=0x0F -> s1 receives both in one cycle with s1_wmask=0x0F; s1 bvalid -> m_bvalid=1, m_bresp=0.
- AW to 0x8000_0100 three cycles before W -> AW accepted in W_IDLE; W forwarded to s0 only in W_DATA; s1_wvalid stays 0 throughout.
- Read in flight to s1 while a write goes to s0; hold m_rready=0 for 4 cycles -> write completes independently; a second m_arvalid sees m_arready=0 until the R handshake.
- Assert reset in W_RESP -> next cycle m_bvalid=0 and the FSM is in W_IDLE; a subsequent write completes normally.
